// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between the instruction fetch path and the
//   load/store path. Only one transaction is outstanding at a time. Data
//   accesses win over fetch, but after MAX_DBURST consecutive data grants
//   while fetch is waiting, fetch is served next. Every output is registered.
//
// Ports
//   clk, rst         : clock, synchronous active-low reset
//   if_req/if_addr   : fetch request, held until if_gnt
//   if_gnt           : one-cycle pulse, fetch accepted
//   if_rvalid/rdata  : one-cycle pulse with fetched word (rdata holds)
//   d_req/we/addr/wdata : data request, held until d_gnt
//   d_gnt            : one-cycle pulse, data op accepted
//   d_rvalid/rdata   : one-cycle pulse, op complete; rdata is 0 for stores
//   m_req/we/addr/wdata : memory request, held for the whole transaction
//   m_ack/m_rdata    : memory completion and read data
//   busy             : a transaction is in flight
//
// state   | meaning
// IDLE    | no transaction; arbitrate on this edge
// IF_WAIT | fetch transaction on the memory port, waiting for m_ack
// D_WAIT  | data transaction on the memory port, waiting for m_ack

module mem_port_arbiter #(
  parameter int AW         = 30,
  parameter int DW         = 32,
  parameter int MAX_DBURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic          m_ack,
  input  logic [DW-1:0] m_rdata,
  output logic          busy
);

  localparam int SW = $clog2(MAX_DBURST + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DBURST);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_WAIT = 2'd1,
    D_WAIT  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [SW-1:0] streak;
  logic          win_d;
  logic          win_if;
  logic          done;

  always_comb begin
    state_nxt = state;
    win_d     = 1'b0;
    win_if    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        // Data wins unless fetch is waiting and the data streak is used up.
        if (d_req && (!if_req || (streak < STREAK_MAX))) begin
          win_d     = 1'b1;
          state_nxt = D_WAIT;
        end else if (if_req) begin
          win_if    = 1'b1;
          state_nxt = IF_WAIT;
        end
      end
      IF_WAIT, D_WAIT: begin
        if (m_ack) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      streak    <= '0;
      busy      <= 1'b0;
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      m_req     <= 1'b0;
      m_we      <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
    end else begin
      state     <= state_nxt;
      busy      <= (state_nxt != IDLE);
      if_gnt    <= win_if;
      d_gnt     <= win_d;
      if_rvalid <= done && (state == IF_WAIT);
      d_rvalid  <= done && (state == D_WAIT);

      if (win_d) begin
        m_req   <= 1'b1;
        m_we    <= d_we;
        m_addr  <= d_addr;
        m_wdata <= d_wdata;
        // Streak only grows while fetch is actually being held off.
        if (!if_req)
          streak <= '0;
        else if (streak != STREAK_MAX)
          streak <= streak + SW'(1);
      end else if (win_if) begin
        m_req   <= 1'b1;
        m_we    <= 1'b0;
        m_addr  <= if_addr;
        m_wdata <= '0;
        streak  <= '0;
      end else if (done) begin
        m_req <= 1'b0;
        m_we  <= 1'b0;
        if (state == IF_WAIT)
          if_rdata <= m_rdata;
        else
          // m_we still reflects the completing op; stores return zero.
          d_rdata <= m_we ? '0 : m_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int AW = 30;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          m_req;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_ack;
  logic [DW-1:0] m_rdata;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_DBURST(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle; outputs are sampled and inputs
  // driven 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".if_gnt"},    32'(if_gnt),    32'd0);
    check({tag, ".d_gnt"},     32'(d_gnt),     32'd0);
    check({tag, ".if_rvalid"}, 32'(if_rvalid), 32'd0);
    check({tag, ".d_rvalid"},  32'(d_rvalid),  32'd0);
    check({tag, ".m_req"},     32'(m_req),     32'd0);
    check({tag, ".m_we"},      32'(m_we),      32'd0);
    check({tag, ".busy"},      32'(busy),      32'd0);
  endtask

  initial begin
    rst = 1'b0; if_req = 1'b1; if_addr = 30'h10;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    m_ack = 1'b0; m_rdata = '0;

    // Reset held two cycles with a fetch pending.
    for (int i = 0; i < 2; i++) begin
      step();
      check_idle_outputs("rst");
      check("rst.if_rdata", if_rdata, 32'd0);
      check("rst.d_rdata",  d_rdata,  32'd0);
      check("rst.m_addr",   32'(m_addr), 32'd0);
      check("rst.m_wdata",  m_wdata,  32'd0);
    end
    rst = 1'b1;

    // Single fetch, acked in the cycle after the grant.
    step();
    check("fetch.if_gnt", 32'(if_gnt), 32'd1);
    check("fetch.d_gnt",  32'(d_gnt),  32'd0);
    check("fetch.m_req",  32'(m_req),  32'd1);
    check("fetch.m_we",   32'(m_we),   32'd0);
    check("fetch.m_addr", 32'(m_addr), 32'h10);
    check("fetch.busy",   32'(busy),   32'd1);
    if_req = 1'b0; m_ack = 1'b1; m_rdata = 32'h8C410004;
    step();
    check("fetch.if_rvalid", 32'(if_rvalid), 32'd1);
    check("fetch.if_rdata",  if_rdata, 32'h8C410004);
    check("fetch.gnt_gone",  32'(if_gnt), 32'd0);
    check("fetch.m_req_off", 32'(m_req), 32'd0);
    check("fetch.busy_off",  32'(busy),  32'd0);
    m_ack = 1'b0; m_rdata = 32'h0;
    step();
    check_idle_outputs("fetch_after");
    check("fetch.rdata_hold", if_rdata, 32'h8C410004);

    // Store with three wait cycles; inputs change after the grant.
    d_req = 1'b1; d_we = 1'b1; d_addr = 30'h20; d_wdata = 32'hDEADBEEF;
    step();
    check("store.d_gnt", 32'(d_gnt), 32'd1);
    d_req = 1'b0; d_we = 1'b0; d_addr = 30'h3FF; d_wdata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      check("store.m_we",    32'(m_we),   32'd1);
      check("store.m_req",   32'(m_req),  32'd1);
      check("store.m_addr",  32'(m_addr), 32'h20);
      check("store.m_wdata", m_wdata,     32'hDEADBEEF);
      check("store.no_rv",   32'(d_rvalid), 32'd0);
      if (i == 3) begin
        m_ack = 1'b1; m_rdata = 32'h12345678;
      end
      step();
    end
    check("store.d_rvalid", 32'(d_rvalid), 32'd1);
    check("store.d_rdata",  d_rdata, 32'd0);
    check("store.m_we_off", 32'(m_we), 32'd0);
    check("store.busy_off", 32'(busy), 32'd0);
    m_ack = 1'b0;
    step();
    check("store.rv_pulse", 32'(d_rvalid), 32'd0);

    // Collision with streak 0: data first, then fetch.
    if_req = 1'b1; if_addr = 30'h40;
    d_req = 1'b1; d_we = 1'b0; d_addr = 30'h50;
    step();
    check("coll.d_gnt",  32'(d_gnt),  32'd1);
    check("coll.if_gnt", 32'(if_gnt), 32'd0);
    check("coll.m_addr", 32'(m_addr), 32'h50);
    d_req = 1'b0; m_ack = 1'b1; m_rdata = 32'hCAFE0001;
    step();
    check("coll.d_rvalid", 32'(d_rvalid), 32'd1);
    check("coll.d_rdata",  d_rdata, 32'hCAFE0001);
    check("coll.no_if_gnt_at_ack", 32'(if_gnt), 32'd0);
    m_ack = 1'b0;
    step();
    check("coll.if_gnt_late", 32'(if_gnt), 32'd1);
    check("coll.m_addr_if",   32'(m_addr), 32'h40);
    check("coll.m_we_if",     32'(m_we),   32'd0);
    if_req = 1'b0; m_ack = 1'b1; m_rdata = 32'h0000ABCD;
    step();
    check("coll.if_rvalid", 32'(if_rvalid), 32'd1);
    check("coll.if_rdata",  if_rdata, 32'h0000ABCD);
    check("coll.d_rdata_hold", d_rdata, 32'hCAFE0001);
    m_ack = 1'b0;

    // Starvation guard: four data grants, then fetch, then data again.
    if_req = 1'b1; if_addr = 30'h60;
    for (int k = 0; k < 4; k++) begin
      d_req = 1'b1; d_addr = 30'(32'h100 + k);
      step();
      check("starve.d_gnt",  32'(d_gnt),  32'd1);
      check("starve.if_gnt", 32'(if_gnt), 32'd0);
      check("starve.m_addr", 32'(m_addr), 32'h100 + 32'(k));
      d_req = 1'b0; m_ack = 1'b1; m_rdata = 32'hA0 + 32'(k);
      step();
      check("starve.d_rvalid", 32'(d_rvalid), 32'd1);
      check("starve.d_rdata",  d_rdata, 32'hA0 + 32'(k));
      m_ack = 1'b0;
    end
    d_req = 1'b1; d_addr = 30'h200;
    step();
    check("starve.if_wins", 32'(if_gnt), 32'd1);
    check("starve.d_held",  32'(d_gnt),  32'd0);
    check("starve.m_addr_if", 32'(m_addr), 32'h60);
    if_req = 1'b0; m_ack = 1'b1; m_rdata = 32'h11112222;
    step();
    check("starve.if_rvalid", 32'(if_rvalid), 32'd1);
    check("starve.if_rdata",  if_rdata, 32'h11112222);
    m_ack = 1'b0;
    step();
    check("starve.d_resume",  32'(d_gnt),  32'd1);
    check("starve.m_addr_d",  32'(m_addr), 32'h200);
    d_req = 1'b0; m_ack = 1'b1; m_rdata = 32'h33334444;
    step();
    check("starve.d_rvalid2", 32'(d_rvalid), 32'd1);
    m_ack = 1'b0;
    step();

    // Reset while a store is in D_WAIT; late m_ack must be ignored.
    d_req = 1'b1; d_we = 1'b1; d_addr = 30'h70; d_wdata = 32'h55AA55AA;
    step();
    check("midrst.d_gnt", 32'(d_gnt), 32'd1);
    d_req = 1'b0; d_we = 1'b0;
    step();
    check("midrst.busy_before", 32'(busy), 32'd1);
    rst = 1'b0;
    step();
    check_idle_outputs("midrst");
    check("midrst.m_addr", 32'(m_addr), 32'd0);
    check("midrst.d_rdata", d_rdata, 32'd0);
    rst = 1'b1; m_ack = 1'b1; m_rdata = 32'hFFFFFFFF;
    step();
    check_idle_outputs("midrst_ack");
    m_ack = 1'b0;
    step();
    check("midrst.no_rv_late", 32'(d_rvalid), 32'd0);
    check("midrst.d_rdata_late", d_rdata, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single memory port between the fetch path (next PC) and the load/store path (ALU address, GPR B data), with one transaction outstanding at a time. It replaces the direct `next_pc` / `memory_address_in` / `S` hookup into memory. Data accesses have priority, and a streak limit guarantees fetch forward progress. Each requester gets a one-cycle grant pulse and a one-cycle completion pulse carrying read data.

## Interface
- AW, 30, word-address width (matches `memory_address_in[29:0]`)
- DW, 32, data width
- MAX_DBURST, 4, consecutive data grants allowed while fetch waits; must be ≥1

- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-low
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  AW  fetch word address
- if_gnt  out  1  one-cycle pulse: fetch accepted
- if_rvalid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  DW  fetched instruction
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data word address
- d_wdata  in  DW  store data
- d_gnt  out  1  one-cycle pulse: data accepted
- d_rvalid  out  1  one-cycle pulse: data op complete; d_rdata valid for loads
- d_rdata  out  DW  load data; 0 for stores
- m_req  out  1  memory request, high for the whole transaction
- m_we  out  1  memory write enable; 0 whenever m_req=0
- m_addr  out  AW  memory address
- m_wdata  out  DW  memory write data
- m_ack  in  1  memory completes the transaction in this cycle; ignored while m_req=0
- m_rdata  in  DW  read data, valid when m_ack=1
- busy  out  1  transaction in flight (state ≠ IDLE)

## Operation
- States: IDLE, IF_WAIT, D_WAIT. Every output is registered.
- **IDLE arbitration**, evaluated at the edge:
  - d_req only: data wins.
  - if_req only: fetch wins.
  - Both, streak < MAX_DBURST: data wins.
  - Both, streak = MAX_DBURST: fetch wins.
  - Neither: stay in IDLE.
- **Win actions:**
  - Latch the winner's addr, we (fetch forces 0) and wdata into m_addr/m_we/m_wdata.
  - Set m_req=1 and go to the matching WAIT state.
  - Pulse the winner's gnt for the next cycle.
- **WAIT:** all requester inputs are ignored. Hold m_* stable until m_ack=1. On that edge:
  - Clear m_req and m_we; go to IDLE.
  - Pulse the owner's rvalid.
  - Load owner rdata with m_rdata, or with 0 for a store.
- **Streak counter:** ceil(log2(MAX_DBURST+1)) bits.
  - Data grant with if_req=1: increment, saturating at MAX_DBURST.
  - Data grant with if_req=0: set to 0.
  - Fetch grant: set to 0.
- **Requester obligation:** drop req in the cycle its gnt is high. A req still high when the arbiter returns to IDLE counts as a new request.
- if_rdata/d_rdata hold their value until the next load of that port.

## Timing
- **Reset**, at an edge with rst=0, regardless of state:
  - state=IDLE, streak=0.
  - All outputs 0: gnt, rvalid, rdata, m_req, m_we, m_addr, m_wdata, busy.
  - An in-flight transaction is abandoned. No rvalid is issued, and an m_ack arriving after reset is ignored.
- **Latency:** request sampled at edge N gives gnt, m_req and busy high in cycle N+1. m_ack high in cycle K≥N+1 gives rvalid in cycle K+1, with m_req=0 and busy=0 in that same cycle.
- **Throughput:** at best one transaction per 2 cycles (WAIT with immediate ack, then IDLE).
- **Simultaneous events:** a new req arriving in the same cycle as m_ack is not arbitrated until the following IDLE edge.
- gnt and rvalid never both high on one port in the same cycle. Both ports can never be granted in the same cycle.

## Test plan
- **Reset:** hold rst=0 for 2 cycles with if_req=1 → every output 0, no gnt. Release → if_gnt pulses exactly one cycle after the first edge with rst=1.
- **Single fetch:** if_addr=0x10, m_ack one cycle later, m_rdata=0x8C410004 → m_addr=0x10 and m_we=0 while m_req=1. if_rvalid=1 with if_rdata=0x8C410004 for one cycle, then busy=0.
- **Store:** d_we=1, d_addr=0x20, d_wdata=0xDEADBEEF, m_ack after 3 wait cycles → m_we=1 for exactly 4 cycles with stable m_addr/m_wdata. Then d_rvalid=1 and d_rdata=0.
- **Collision:** if_req and d_req sampled together, streak=0 → d_gnt first. After its rvalid, if_gnt is granted at the next IDLE edge.
- **Starvation guard:** if_req held high, d_req reasserted each IDLE, MAX_DBURST=4 → exactly 4 data grants, then if_gnt, then data resumes.
- **Reset mid-transaction:** rst=0 while in D_WAIT, m_ack=1 in the following cycle → no d_rvalid, state IDLE, m_req=0.
